// File: rtl/hpm_overflow_ctrl.sv
// Overflow tracking and privilege filter for the generic HPM counters.
// Latches sticky per-counter OF bits, raises LCOFI and gates counting by privilege.
module hpm_overflow_ctrl #(
    parameter int unsigned NumCounters  = 6,
    parameter int unsigned CounterWidth = 64
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic [1:0]                                priv_lvl_i,
    input  logic                                      debug_mode_i,
    input  logic [NumCounters-1:0][CounterWidth-1:0]  counter_i,
    input  logic [NumCounters-1:0]                    incr_i,
    input  logic                                      ctrl_we_i,
    input  logic [2:0]                                ctrl_idx_i,
    input  logic [3:0]                                ctrl_wdata_i,
    output logic [3:0]                                ctrl_rdata_o,
    input  logic                                      lcofip_clr_i,
    output logic [NumCounters-1:0]                    count_en_o,
    output logic [NumCounters-1:0]                    scountovf_o,
    output logic                                      lcofi_o
);

    localparam logic [1:0] PrivU = 2'b00;
    localparam logic [1:0] PrivS = 2'b01;
    localparam logic [1:0] PrivM = 2'b11;

    logic [NumCounters-1:0] of_q, of_d;
    logic [NumCounters-1:0] minh_q, minh_d;
    logic [NumCounters-1:0] sinh_q, sinh_d;
    logic [NumCounters-1:0] uinh_q, uinh_d;
    logic                   lcofi_q, lcofi_d;

    logic [NumCounters-1:0] ovf;
    logic [NumCounters-1:0] wr_sel;
    logic [NumCounters-1:0] first_ovf;

    for (genvar gi = 0; gi < NumCounters; gi++) begin : g_cnt
        assign ovf[gi]       = incr_i[gi] & (&counter_i[gi]);
        assign wr_sel[gi]    = ctrl_we_i & (ctrl_idx_i == 3'(gi));
        // Only a hardware-driven 0->1 transition of OF may raise the interrupt.
        assign first_ovf[gi] = ovf[gi] & ~of_q[gi];

        always_comb begin
            count_en_o[gi] = 1'b0;
            if (!debug_mode_i) begin
                unique case (priv_lvl_i)
                    PrivM:   count_en_o[gi] = ~minh_q[gi];
                    PrivS:   count_en_o[gi] = ~sinh_q[gi];
                    PrivU:   count_en_o[gi] = ~uinh_q[gi];
                    default: count_en_o[gi] = 1'b0;
                endcase
            end
        end
    end

    always_comb begin
        of_d   = of_q;
        minh_d = minh_q;
        sinh_d = sinh_q;
        uinh_d = uinh_q;
        for (int k = 0; k < int'(NumCounters); k++) begin
            if (ovf[k]) begin
                of_d[k] = 1'b1;
            end else if (wr_sel[k]) begin
                of_d[k] = ctrl_wdata_i[3];
            end
            if (wr_sel[k]) begin
                minh_d[k] = ctrl_wdata_i[2];
                sinh_d[k] = ctrl_wdata_i[1];
                uinh_d[k] = ctrl_wdata_i[0];
            end
        end
    end

    always_comb begin
        lcofi_d = lcofi_q;
        if (|first_ovf) begin
            lcofi_d = 1'b1;
        end else if (lcofip_clr_i) begin
            lcofi_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            of_q    <= '0;
            minh_q  <= '0;
            sinh_q  <= '0;
            uinh_q  <= '0;
            lcofi_q <= 1'b0;
        end else begin
            of_q    <= of_d;
            minh_q  <= minh_d;
            sinh_q  <= sinh_d;
            uinh_q  <= uinh_d;
            lcofi_q <= lcofi_d;
        end
    end

    // Out-of-range indices fall through the loop and read back as zero.
    always_comb begin
        ctrl_rdata_o = 4'b0000;
        for (int k = 0; k < int'(NumCounters); k++) begin
            if (ctrl_idx_i == 3'(k)) begin
                ctrl_rdata_o = {of_q[k], minh_q[k], sinh_q[k], uinh_q[k]};
            end
        end
    end

    assign scountovf_o = of_q;
    assign lcofi_o     = lcofi_q;

endmodule

// File: tb/tb_hpm_overflow_ctrl.sv
// Bench for hpm_overflow_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural model of the overflow/inhibit rules.
module tb_hpm_overflow_ctrl;

    localparam int N = 6;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic            clk;
    logic            rst_n;
    logic [1:0]      priv;
    logic            debug;
    logic [N-1:0][63:0] counter;
    logic [N-1:0]    incr;
    logic            we;
    logic [2:0]      idx;
    logic [3:0]      wdata;
    logic [3:0]      rdata;
    logic            clr;
    logic [N-1:0]    count_en;
    logic [N-1:0]    scountovf;
    logic            lcofi;

    int n_run  = 0;
    int n_fail = 0;

    // Behavioural model state
    bit m_of   [N];
    bit m_minh [N];
    bit m_sinh [N];
    bit m_uinh [N];
    bit m_lcofi;

    hpm_overflow_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .priv_lvl_i   (priv),
        .debug_mode_i (debug),
        .counter_i    (counter),
        .incr_i       (incr),
        .ctrl_we_i    (we),
        .ctrl_idx_i   (idx),
        .ctrl_wdata_i (wdata),
        .ctrl_rdata_o (rdata),
        .lcofip_clr_i (clr),
        .count_en_o   (count_en),
        .scountovf_o  (scountovf),
        .lcofi_o      (lcofi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] exp_of();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = m_of[k];
        return v;
    endfunction

    // A counter may count unless debug is active, the privilege is reserved,
    // or the inhibit bit belonging to the current privilege mode is set.
    function automatic logic [N-1:0] exp_en();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) begin
            bit inhibited;
            case (priv)
                2'b11:   inhibited = m_minh[k];
                2'b01:   inhibited = m_sinh[k];
                2'b00:   inhibited = m_uinh[k];
                default: inhibited = 1'b1;
            endcase
            v[k] = !(debug || inhibited);
        end
        return v;
    endfunction

    function automatic logic [3:0] exp_rd(input logic [2:0] i);
        if (int'(i) >= N) return 4'b0000;
        return {m_of[i], m_minh[i], m_sinh[i], m_uinh[i]};
    endfunction

    // Advance one clock: the model consumes the inputs present at the edge,
    // then single-cycle pulse inputs are dropped.
    task automatic tick();
        bit n_of [N];
        bit n_mi [N];
        bit n_si [N];
        bit n_ui [N];
        bit n_l;
        bit any_new;
        any_new = 1'b0;
        n_l = m_lcofi;
        for (int k = 0; k < N; k++) begin
            n_of[k] = m_of[k]; n_mi[k] = m_minh[k]; n_si[k] = m_sinh[k]; n_ui[k] = m_uinh[k];
        end
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                n_of[k] = 0; n_mi[k] = 0; n_si[k] = 0; n_ui[k] = 0;
            end
            n_l = 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                bit wraps;
                bit wr;
                wraps = incr[k] && ((counter[k] + 64'd1) == 64'd0);
                wr    = we && (int'(idx) == k);
                if (wraps) begin
                    if (!m_of[k]) any_new = 1'b1;
                    n_of[k] = 1'b1;
                end else if (wr) begin
                    n_of[k] = wdata[3];
                end
                if (wr) begin
                    n_mi[k] = wdata[2]; n_si[k] = wdata[1]; n_ui[k] = wdata[0];
                end
            end
            if (any_new) n_l = 1'b1;
            else if (clr) n_l = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            m_of[k] = n_of[k]; m_minh[k] = n_mi[k]; m_sinh[k] = n_si[k]; m_uinh[k] = n_ui[k];
        end
        m_lcofi = n_l;
        incr = '0;
        we   = 1'b0;
        clr  = 1'b0;
        #1;
    endtask

    task automatic sw_write(input logic [2:0] i, input logic [3:0] d);
        we = 1'b1; idx = i; wdata = d;
        tick();
    endtask

    task automatic test_reset();
        n_run++;
        if (scountovf !== 6'b000000) begin
            n_fail++; $display("FAIL reset_of: got %b want %b", scountovf, 6'b000000);
        end
        n_run++;
        if (lcofi !== 1'b0) begin
            n_fail++; $display("FAIL reset_lcofi: got %b want 0", lcofi);
        end
        n_run++;
        if (count_en !== 6'b111111) begin
            n_fail++; $display("FAIL reset_en: got %b want %b", count_en, 6'b111111);
        end
        idx = 3'd0; #1;
        n_run++;
        if (rdata !== 4'b0000) begin
            n_fail++; $display("FAIL reset_rdata: got %b want 0000", rdata);
        end
        $display("[TB] reset: of=%b lcofi=%b en=%b", scountovf, lcofi, count_en);
    endtask

    task automatic test_wrap();
        counter[0] = ONES; incr[0] = 1'b1;
        tick();
        n_run++;
        if (scountovf !== 6'b000001 || lcofi !== 1'b1) begin
            n_fail++; $display("FAIL wrap: got of=%b lcofi=%b want of=000001 lcofi=1", scountovf, lcofi);
        end
        clr = 1'b1;
        tick();
        n_run++;
        if (scountovf !== 6'b000001 || lcofi !== 1'b0) begin
            n_fail++; $display("FAIL wrap_clr: got of=%b lcofi=%b want of=000001 lcofi=0", scountovf, lcofi);
        end
        counter[0] = 64'd5;
        $display("[TB] wrap: of=%b lcofi=%b", scountovf, lcofi);
    endtask

    task automatic test_sw_set();
        counter[2] = ONES; incr[2] = 1'b0;
        tick();
        n_run++;
        if (scountovf[2] !== 1'b0) begin
            n_fail++; $display("FAIL no_incr_no_of: got %b want 0", scountovf[2]);
        end
        sw_write(3'd2, 4'b1000);
        n_run++;
        if (scountovf !== 6'b000101 || lcofi !== 1'b0) begin
            n_fail++; $display("FAIL sw_set: got of=%b lcofi=%b want of=000101 lcofi=0", scountovf, lcofi);
        end
        incr[2] = 1'b1;
        tick();
        n_run++;
        if (scountovf[2] !== 1'b1 || lcofi !== 1'b0) begin
            n_fail++; $display("FAIL reovf_no_irq: got of2=%b lcofi=%b want of2=1 lcofi=0", scountovf[2], lcofi);
        end
        counter[2] = 64'd0;
        $display("[TB] sw_set: of=%b lcofi=%b", scountovf, lcofi);
    endtask

    task automatic test_simultaneous();
        counter[3] = ONES; incr[3] = 1'b1;
        we = 1'b1; idx = 3'd3; wdata = 4'b0000;
        tick();
        n_run++;
        if (scountovf[3] !== 1'b1 || lcofi !== 1'b1) begin
            n_fail++; $display("FAIL ovf_beats_write: got of3=%b lcofi=%b want 1 1", scountovf[3], lcofi);
        end
        clr = 1'b1;
        tick();
        counter[4] = ONES; incr[4] = 1'b1; clr = 1'b1;
        tick();
        n_run++;
        if (lcofi !== 1'b1 || scountovf !== 6'b011101) begin
            n_fail++; $display("FAIL ovf_beats_clr: got of=%b lcofi=%b want of=011101 lcofi=1", scountovf, lcofi);
        end
        counter[3] = 64'd0; counter[4] = 64'd0;
        $display("[TB] simultaneous: of=%b lcofi=%b", scountovf, lcofi);
    endtask

    task automatic test_priv_filter();
        sw_write(3'd1, 4'b0010);
        priv = 2'b01; #1;
        n_run++;
        if (count_en !== 6'b111101) begin
            n_fail++; $display("FAIL en_s: got %b want 111101", count_en);
        end
        priv = 2'b11; #1;
        n_run++;
        if (count_en !== 6'b111111) begin
            n_fail++; $display("FAIL en_m: got %b want 111111", count_en);
        end
        debug = 1'b1; #1;
        n_run++;
        if (count_en !== 6'b000000) begin
            n_fail++; $display("FAIL en_debug: got %b want 000000", count_en);
        end
        debug = 1'b0; priv = 2'b10; #1;
        n_run++;
        if (count_en !== 6'b000000) begin
            n_fail++; $display("FAIL en_reserved: got %b want 000000", count_en);
        end
        priv = 2'b11; #1;
        $display("[TB] priv_filter: en(M)=%b", count_en);
    endtask

    task automatic test_reset_mid();
        counter[1] = ONES; incr[1] = 1'b1;
        tick();
        counter[1] = 64'd0;
        sw_write(3'd3, 4'b1000);
        sw_write(3'd5, 4'b1000);
        sw_write(3'd0, 4'b0111);
        sw_write(3'd2, 4'b0111);
        n_run++;
        if (scountovf !== exp_of() || lcofi !== m_lcofi) begin
            n_fail++; $display("FAIL mid_setup: got of=%b lcofi=%b want of=%b lcofi=%b", scountovf, lcofi, exp_of(), m_lcofi);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_run++;
        if (scountovf !== 6'b000000 || lcofi !== 1'b0 || count_en !== 6'b111111) begin
            n_fail++; $display("FAIL mid_reset: got of=%b lcofi=%b en=%b want 000000 0 111111", scountovf, lcofi, count_en);
        end
        for (int i = 0; i < N; i++) begin
            idx = 3'(i); #1;
            n_run++;
            if (rdata !== 4'b0000) begin
                n_fail++; $display("FAIL mid_reset_rdata%0d: got %b want 0000", i, rdata);
            end
        end
        $display("[TB] reset_mid: of=%b lcofi=%b en=%b", scountovf, lcofi, count_en);
    endtask

    task automatic test_multi_ovf();
        counter[0] = ONES; counter[5] = ONES; incr = 6'b100001;
        tick();
        n_run++;
        if (scountovf !== 6'b100001 || lcofi !== 1'b1) begin
            n_fail++; $display("FAIL multi_ovf: got of=%b lcofi=%b want of=100001 lcofi=1", scountovf, lcofi);
        end
        counter[0] = 64'd0; counter[5] = 64'd0;
        $display("[TB] multi_ovf: of=%b lcofi=%b", scountovf, lcofi);
    endtask

    task automatic test_out_of_range();
        sw_write(3'd7, 4'b1111);
        n_run++;
        if (scountovf !== 6'b100001 || count_en !== 6'b111111) begin
            n_fail++; $display("FAIL oor_write: got of=%b en=%b want of=100001 en=111111", scountovf, count_en);
        end
        idx = 3'd7; #1;
        n_run++;
        if (rdata !== 4'b0000) begin
            n_fail++; $display("FAIL oor_read: got %b want 0000", rdata);
        end
        $display("[TB] out_of_range: rdata=%b", rdata);
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < N; k++) begin
                counter[k] = ($urandom_range(0, 2) == 0) ? ONES : {$urandom, $urandom};
                incr[k]    = 1'($urandom_range(0, 1));
            end
            we    = ($urandom_range(0, 3) == 0);
            idx   = 3'($urandom_range(0, 7));
            wdata = 4'($urandom);
            clr   = ($urandom_range(0, 4) == 0);
            priv  = 2'($urandom);
            debug = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 49) != 0);
            tick();
            rst_n = 1'b1;
            idx = 3'($urandom_range(0, 7)); #1;
            n_run++;
            if (scountovf !== exp_of() || lcofi !== m_lcofi || count_en !== exp_en() || rdata !== exp_rd(idx)) begin
                n_fail++; errs++;
                $display("FAIL rand%0d: got of=%b lcofi=%b en=%b rd=%b want of=%b lcofi=%b en=%b rd=%b",
                         c, scountovf, lcofi, count_en, rdata, exp_of(), m_lcofi, exp_en(), exp_rd(idx));
            end
        end
        $display("[TB] random: 300 cycles, %0d mismatching", errs);
    endtask

    initial begin
        rst_n = 1'b0; priv = 2'b11; debug = 1'b0;
        counter = '0; incr = '0; we = 1'b0; idx = 3'd0; wdata = 4'd0; clr = 1'b0;
        m_lcofi = 1'b0;
        for (int k = 0; k < N; k++) begin
            m_of[k] = 0; m_minh[k] = 0; m_sinh[k] = 0; m_uinh[k] = 0;
        end
        tick();
        tick();
        rst_n = 1'b1;
        test_reset();
        test_wrap();
        test_sw_set();
        test_simultaneous();
        test_priv_filter();
        test_reset_mid();
        test_multi_ovf();
        test_out_of_range();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
